// File: rtl/pgm_loader_pkg.sv
// Shared constants for the PIC16C55 serial programming loader: widths, command codes, FSM states.
package pgm_loader_pkg;

    localparam int PC_WIDTH       = 9;
    localparam int INST_WIDTH     = 12;
    localparam int PGM_CMD_BITS   = 6;
    localparam int PGM_FRAME_BITS = 16;
    localparam int PGM_STATE_BITS = 3;

    localparam logic [PGM_CMD_BITS-1:0] PGM_CMD_LOAD = 6'h02;
    localparam logic [PGM_CMD_BITS-1:0] PGM_CMD_READ = 6'h04;
    localparam logic [PGM_CMD_BITS-1:0] PGM_CMD_INC  = 6'h06;
    localparam logic [PGM_CMD_BITS-1:0] PGM_CMD_PROG = 6'h08;

    typedef enum logic [PGM_STATE_BITS-1:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_DATA_IN  = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DATA_OUT = 3'd4
    } pgm_state_e;

endpackage

// File: rtl/pgm_sync.sv
// Multi-flop synchronizer for one asynchronous input with registered rising/falling edge pulses.
module pgm_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/pgm_loader.sv
// Serial in-circuit programming loader: 6-bit commands / 16-bit data frames, LSB first.
// Optional readback over pgmDataOut is enabled by defining LOADER_READBACK_EN.
module pgm_loader
    import pgm_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = PC_WIDTH,
    parameter int DATA_WIDTH  = INST_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pgmModeIn,
    input  logic                  pgmClkIn,
    input  logic                  pgmDataIn,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    output logic [ADDR_WIDTH-1:0] memAddrOut,
    output logic [DATA_WIDTH-1:0] memDataOut,
    output logic                  memWeOut,
    output logic                  coreRstNOut,
    output logic                  busyOut,
    output logic                  pgmDataOut,
    output logic                  pgmDataOE
);

    localparam logic [4:0] CMD_LAST   = 5'(PGM_CMD_BITS - 1);
    localparam logic [4:0] FRAME_LAST = 5'(PGM_FRAME_BITS - 1);
    localparam logic [4:0] FRAME_DONE = 5'(PGM_FRAME_BITS);

    // Index 0: mode, 1: serial clock, 2: serial data
    logic [2:0] async_in;
    logic [2:0] lvl;
    logic [2:0] rise;
    logic [2:0] fall;

    assign async_in = {pgmDataIn, pgmClkIn, pgmModeIn};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            pgm_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk     (clk),
                .rst_n   (rst_n),
                .async_i (async_in[gi]),
                .level_o (lvl[gi]),
                .rise_o  (rise[gi]),
                .fall_o  (fall[gi])
            );
        end
    endgenerate

    logic mode_lvl;
    logic pgm_rise;
    logic pgm_data;
    assign mode_lvl = lvl[0];
    assign pgm_rise = rise[1];
    assign pgm_data = lvl[2];

    pgm_state_e                state_q, state_d;
    logic [4:0]                cnt_q, cnt_d;
    logic [PGM_FRAME_BITS-2:0] sh_q, sh_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;

    // Frame as it stands once the bit sampled on this edge is included
    logic [PGM_FRAME_BITS-1:0] frame;
    logic [PGM_CMD_BITS-1:0]   cmd;
    assign frame = {pgm_data, sh_q};
    assign cmd   = frame[PGM_FRAME_BITS-1 -: PGM_CMD_BITS];

`ifdef LOADER_READBACK_EN
    logic [PGM_FRAME_BITS-1:0] out_sh_q, out_sh_d;
    logic                      dout_q, dout_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef LOADER_READBACK_EN
        out_sh_d = out_sh_q;
        dout_d   = dout_q;
`endif
        if (pgm_rise) begin
            sh_d = frame[PGM_FRAME_BITS-1:1];
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (mode_lvl) begin
                    state_d = ST_CMD;
                    addr_d  = '0;
                end
            end
            ST_CMD: begin
                if (!mode_lvl) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (pgm_rise) begin
                    if (cnt_q == CMD_LAST) begin
                        cnt_d = '0;
                        case (cmd)
                            PGM_CMD_LOAD: state_d = ST_DATA_IN;
                            PGM_CMD_INC:  addr_d  = addr_q + ADDR_WIDTH'(1);
                            PGM_CMD_PROG: state_d = ST_WRITE;
`ifdef LOADER_READBACK_EN
                            PGM_CMD_READ: begin
                                state_d  = ST_DATA_OUT;
                                out_sh_d = {{(PGM_FRAME_BITS-DATA_WIDTH-1){1'b0}}, memDataIn, 1'b0};
                                dout_d   = 1'b0;
                            end
`else
                            PGM_CMD_READ: ;
`endif
                            default: ;
                        endcase
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            ST_DATA_IN: begin
                if (!mode_lvl) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (pgm_rise) begin
                    if (cnt_q == FRAME_LAST) begin
                        cnt_d   = '0;
                        data_d  = frame[DATA_WIDTH:1];
                        state_d = ST_CMD;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            // The strobe always completes; a mode drop is honoured afterwards
            ST_WRITE: state_d = mode_lvl ? ST_CMD : ST_IDLE;
            ST_DATA_OUT: begin
`ifdef LOADER_READBACK_EN
                if (!mode_lvl) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == FRAME_DONE) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end else if (pgm_rise) begin
                    cnt_d    = cnt_q + 5'd1;
                    dout_d   = out_sh_q[0];
                    out_sh_d = out_sh_q >> 1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            addr_q   <= '0;
            data_q   <= '1;
`ifdef LOADER_READBACK_EN
            out_sh_q <= '0;
            dout_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
`ifdef LOADER_READBACK_EN
            out_sh_q <= out_sh_d;
            dout_q   <= dout_d;
`endif
        end
    end

    assign memAddrOut  = addr_q;
    assign memDataOut  = data_q;
    assign memWeOut    = (state_q == ST_WRITE);
    assign coreRstNOut = (state_q == ST_IDLE);
    assign busyOut     = (state_q == ST_DATA_IN) || (state_q == ST_WRITE) ||
                         (state_q == ST_DATA_OUT) || ((state_q == ST_CMD) && (cnt_q != '0));

`ifdef LOADER_READBACK_EN
    assign pgmDataOut = dout_q;
    assign pgmDataOE  = (state_q == ST_DATA_OUT);
    logic unused_sink;
    assign unused_sink = ^{rise[0], rise[2], fall, lvl[1], frame[0]};
`else
    assign pgmDataOut = 1'b0;
    assign pgmDataOE  = 1'b0;
    logic unused_sink;
    assign unused_sink = ^{rise[0], rise[2], fall, lvl[1], frame[0], memDataIn};
`endif

endmodule

// File: tb/tb_pgm_loader.sv
// Directed self-checking bench for pgm_loader; readback scenario follows LOADER_READBACK_EN.
module tb_pgm_loader;

    localparam logic [5:0] C_LOAD = 6'h02;
    localparam logic [5:0] C_READ = 6'h04;
    localparam logic [5:0] C_INC  = 6'h06;
    localparam logic [5:0] C_PROG = 6'h08;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pgmModeIn;
    logic        pgmClkIn;
    logic        pgmDataIn;
    logic [11:0] memDataIn;
    logic [8:0]  memAddrOut;
    logic [11:0] memDataOut;
    logic        memWeOut;
    logic        coreRstNOut;
    logic        busyOut;
    logic        pgmDataOut;
    logic        pgmDataOE;

    int pass_cnt = 0;
    int total    = 0;
    int we_cnt   = 0;

    always #5 clk = ~clk;

    pgm_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pgmModeIn   (pgmModeIn),
        .pgmClkIn    (pgmClkIn),
        .pgmDataIn   (pgmDataIn),
        .memDataIn   (memDataIn),
        .memAddrOut  (memAddrOut),
        .memDataOut  (memDataOut),
        .memWeOut    (memWeOut),
        .coreRstNOut (coreRstNOut),
        .busyOut     (busyOut),
        .pgmDataOut  (pgmDataOut),
        .pgmDataOE   (pgmDataOE)
    );

    always @(negedge clk) begin
        if (memWeOut === 1'b1) we_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        pgmDataIn = b;
        pgmClkIn  = 1'b0;
        wait_n(3);
        pgmClkIn  = 1'b1;
        wait_n(3);
    endtask

    task automatic send_frame(input logic [15:0] v, input int nb);
        for (int i = 0; i < nb; i++) send_bit(v[i]);
        pgmClkIn = 1'b0;
        wait_n(4);
    endtask

    task automatic send_cmd(input logic [5:0] c);
        send_frame({10'b0, c}, 6);
    endtask

    task automatic send_load(input logic [11:0] d);
        send_cmd(C_LOAD);
        send_frame({3'b101, d, 1'b1}, 16);
        $display("[tb] LOAD_DATA %h", d);
    endtask

    // Sends a command, raising the clock for its 6th bit; returns 3 cycles after that rise
    task automatic cmd_head(input logic [5:0] c);
        logic [5:0] cv;
        cv = c;
        send_frame({10'b0, cv}, 5);
        pgmDataIn = cv[5];
        wait_n(3);
        pgmClkIn = 1'b1;
        wait_n(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pgmModeIn = 1'b0; pgmClkIn = 1'b0; pgmDataIn = 1'b0;
        memDataIn = 12'h3C9;
        wait_n(3);
        total++; if (memAddrOut !== 9'd0) $display("FAIL rst_addr: got %h expected 000", memAddrOut); else pass_cnt++;
        total++; if (memDataOut !== 12'hFFF) $display("FAIL rst_data: got %h expected fff", memDataOut); else pass_cnt++;
        total++; if (memWeOut !== 1'b0) $display("FAIL rst_we: got %b expected 0", memWeOut); else pass_cnt++;
        total++; if (coreRstNOut !== 1'b1) $display("FAIL rst_core: got %b expected 1", coreRstNOut); else pass_cnt++;
        total++; if (busyOut !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busyOut); else pass_cnt++;
        total++; if (pgmDataOut !== 1'b0) $display("FAIL rst_dout: got %b expected 0", pgmDataOut); else pass_cnt++;
        total++; if (pgmDataOE !== 1'b0) $display("FAIL rst_oe: got %b expected 0", pgmDataOE); else pass_cnt++;
        rst_n = 1'b1;
        wait_n(4);
        total++; if (coreRstNOut !== 1'b1) $display("FAIL idle_core: got %b expected 1", coreRstNOut); else pass_cnt++;
        $display("[tb] reset done");
    endtask

    task automatic test_program();
        int we0;
        pgmModeIn = 1'b1;
        wait_n(2);
        total++; if (coreRstNOut !== 1'b1) $display("FAIL enter_early: got %b expected 1", coreRstNOut); else pass_cnt++;
        wait_n(1);
        total++; if (coreRstNOut !== 1'b0) $display("FAIL enter_core: got %b expected 0", coreRstNOut); else pass_cnt++;
        total++; if (memAddrOut !== 9'd0) $display("FAIL enter_addr: got %h expected 000", memAddrOut); else pass_cnt++;
        wait_n(2);
        send_load(12'hA5C);
        total++; if (memDataOut !== 12'hA5C) $display("FAIL prog_latch: got %h expected a5c", memDataOut); else pass_cnt++;
        we0 = we_cnt;
        cmd_head(C_PROG);
        total++; if (memWeOut !== 1'b0) $display("FAIL prog_we_early: got %b expected 0", memWeOut); else pass_cnt++;
        wait_n(1);
        total++; if (memWeOut !== 1'b1) $display("FAIL prog_we: got %b expected 1", memWeOut); else pass_cnt++;
        total++; if (memAddrOut !== 9'd0) $display("FAIL prog_addr: got %h expected 000", memAddrOut); else pass_cnt++;
        total++; if (memDataOut !== 12'hA5C) $display("FAIL prog_data: got %h expected a5c", memDataOut); else pass_cnt++;
        total++; if (busyOut !== 1'b1) $display("FAIL prog_busy: got %b expected 1", busyOut); else pass_cnt++;
        wait_n(1);
        total++; if (memWeOut !== 1'b0) $display("FAIL prog_we_late: got %b expected 0", memWeOut); else pass_cnt++;
        pgmClkIn = 1'b0;
        wait_n(3);
        total++; if (we_cnt - we0 !== 1) $display("FAIL prog_pulses: got %0d expected 1", we_cnt - we0); else pass_cnt++;
        total++; if (coreRstNOut !== 1'b0) $display("FAIL prog_core: got %b expected 0", coreRstNOut); else pass_cnt++;
        $display("[tb] BEGIN_PROG addr 000 data a5c");
    endtask

    task automatic test_unknown();
        int we0;
        we0 = we_cnt;
        send_cmd(C_INC);
        total++; if (memAddrOut !== 9'd1) $display("FAIL inc_addr: got %h expected 001", memAddrOut); else pass_cnt++;
        send_frame({10'b0, 6'h15}, 3);
        total++; if (busyOut !== 1'b1) $display("FAIL cmd_busy: got %b expected 1", busyOut); else pass_cnt++;
        send_frame({13'b0, 3'b010}, 3);
        total++; if (busyOut !== 1'b0) $display("FAIL unk_busy: got %b expected 0", busyOut); else pass_cnt++;
        total++; if (memAddrOut !== 9'd1) $display("FAIL unk_addr: got %h expected 001", memAddrOut); else pass_cnt++;
        send_load(12'h123);
        total++; if (memDataOut !== 12'h123) $display("FAIL unk_latch: got %h expected 123", memDataOut); else pass_cnt++;
        total++; if (memAddrOut !== 9'd1) $display("FAIL unk_addr2: got %h expected 001", memAddrOut); else pass_cnt++;
        total++; if (we_cnt - we0 !== 0) $display("FAIL unk_write: got %0d expected 0", we_cnt - we0); else pass_cnt++;
        $display("[tb] unknown command 15 ignored");
    endtask

    task automatic test_wrap();
        pgmModeIn = 1'b0;
        wait_n(5);
        total++; if (coreRstNOut !== 1'b1) $display("FAIL exit_core: got %b expected 1", coreRstNOut); else pass_cnt++;
        pgmModeIn = 1'b1;
        wait_n(5);
        total++; if (memAddrOut !== 9'd0) $display("FAIL reenter_addr: got %h expected 000", memAddrOut); else pass_cnt++;
        for (int i = 0; i < 511; i++) send_cmd(C_INC);
        total++; if (memAddrOut !== 9'd511) $display("FAIL wrap_511: got %h expected 1ff", memAddrOut); else pass_cnt++;
        send_cmd(C_INC);
        total++; if (memAddrOut !== 9'd0) $display("FAIL wrap_0: got %h expected 000", memAddrOut); else pass_cnt++;
        send_load(12'h5A5);
        cmd_head(C_PROG);
        wait_n(1);
        total++; if (memWeOut !== 1'b1) $display("FAIL wrap_we: got %b expected 1", memWeOut); else pass_cnt++;
        total++; if (memAddrOut !== 9'd0) $display("FAIL wrap_waddr: got %h expected 000", memAddrOut); else pass_cnt++;
        total++; if (memDataOut !== 12'h5A5) $display("FAIL wrap_wdata: got %h expected 5a5", memDataOut); else pass_cnt++;
        pgmClkIn = 1'b0;
        wait_n(3);
        $display("[tb] 512 INC_ADDR wrapped, write at 000");
    endtask

    task automatic test_abort();
        int we0;
        send_cmd(C_LOAD);
        send_frame(16'h0FFE, 9);
        total++; if (busyOut !== 1'b1) $display("FAIL abort_busy_pre: got %b expected 1", busyOut); else pass_cnt++;
        we0 = we_cnt;
        pgmModeIn = 1'b0;
        wait_n(2);
        total++; if (coreRstNOut !== 1'b0) $display("FAIL abort_core_early: got %b expected 0", coreRstNOut); else pass_cnt++;
        wait_n(1);
        total++; if (coreRstNOut !== 1'b1) $display("FAIL abort_core: got %b expected 1", coreRstNOut); else pass_cnt++;
        total++; if (busyOut !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busyOut); else pass_cnt++;
        total++; if (memDataOut !== 12'h5A5) $display("FAIL abort_latch: got %h expected 5a5", memDataOut); else pass_cnt++;
        total++; if (we_cnt - we0 !== 0) $display("FAIL abort_write: got %0d expected 0", we_cnt - we0); else pass_cnt++;
        pgmModeIn = 1'b1;
        wait_n(5);
        send_load(12'h0F0);
        total++; if (memDataOut !== 12'h0F0) $display("FAIL abort_relaod: got %h expected 0f0", memDataOut); else pass_cnt++;
        $display("[tb] abort after 9 data bits");
    endtask

    task automatic test_readback();
`ifdef LOADER_READBACK_EN
        logic [15:0] exp_stream;
        exp_stream = {3'b000, 12'h3C9, 1'b0};
        cmd_head(C_READ);
        wait_n(1);
        total++; if (pgmDataOE !== 1'b1) $display("FAIL rb_oe_start: got %b expected 1", pgmDataOE); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            pgmClkIn = 1'b0;
            wait_n(3);
            pgmClkIn = 1'b1;
            wait_n(4);
            total++; if (pgmDataOut !== exp_stream[i]) $display("FAIL rb_bit%0d: got %b expected %b", i, pgmDataOut, exp_stream[i]); else pass_cnt++;
            total++; if (pgmDataOE !== 1'b1) $display("FAIL rb_oe%0d: got %b expected 1", i, pgmDataOE); else pass_cnt++;
        end
        wait_n(1);
        total++; if (pgmDataOE !== 1'b0) $display("FAIL rb_oe_end: got %b expected 0", pgmDataOE); else pass_cnt++;
        total++; if (busyOut !== 1'b0) $display("FAIL rb_busy_end: got %b expected 0", busyOut); else pass_cnt++;
        pgmClkIn = 1'b0;
        wait_n(3);
        $display("[tb] READ_DATA streamed 3c9");
`else
        send_cmd(C_READ);
        total++; if (pgmDataOE !== 1'b0) $display("FAIL rb_off_oe: got %b expected 0", pgmDataOE); else pass_cnt++;
        total++; if (busyOut !== 1'b0) $display("FAIL rb_off_busy: got %b expected 0", busyOut); else pass_cnt++;
        send_load(12'h0AB);
        total++; if (memDataOut !== 12'h0AB) $display("FAIL rb_off_latch: got %h expected 0ab", memDataOut); else pass_cnt++;
        total++; if (pgmDataOE !== 1'b0) $display("FAIL rb_off_oe2: got %b expected 0", pgmDataOE); else pass_cnt++;
        $display("[tb] READ_DATA ignored without readback");
`endif
    endtask

    task automatic test_async_reset();
        send_load(12'h777);
        cmd_head(C_PROG);
        wait_n(1);
        total++; if (memWeOut !== 1'b1) $display("FAIL ar_we_pre: got %b expected 1", memWeOut); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (memWeOut !== 1'b0) $display("FAIL ar_we: got %b expected 0", memWeOut); else pass_cnt++;
        total++; if (memDataOut !== 12'hFFF) $display("FAIL ar_data: got %h expected fff", memDataOut); else pass_cnt++;
        total++; if (memAddrOut !== 9'd0) $display("FAIL ar_addr: got %h expected 000", memAddrOut); else pass_cnt++;
        total++; if (coreRstNOut !== 1'b1) $display("FAIL ar_core: got %b expected 1", coreRstNOut); else pass_cnt++;
        total++; if (busyOut !== 1'b0) $display("FAIL ar_busy: got %b expected 0", busyOut); else pass_cnt++;
        total++; if (pgmDataOE !== 1'b0) $display("FAIL ar_oe: got %b expected 0", pgmDataOE); else pass_cnt++;
        pgmModeIn = 1'b0;
        pgmClkIn  = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(3);
        $display("[tb] async reset during WRITE");
    endtask

    initial begin
        test_reset();
        test_program();
        test_unknown();
        test_readback();
        test_wrap();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
